// File: rtl/onchip_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter_if
//
// Purpose : one Avalon-MM master-to-slave link (word addressed, 1-cycle
//           pipelined reads). Each requester of the on-chip RAM arbiter
//           connects through one instance of this interface.
//
// Signals :
//   address       master -> slave  word address
//   byteenable    master -> slave  byte enables for writes
//   read          master -> slave  read request
//   write         master -> slave  write request (wins over read)
//   writedata     master -> slave  write data
//   waitrequest   slave  -> master request not accepted this cycle
//   readdata      slave  -> master read data, qualified by readdatavalid
//   readdatavalid slave  -> master read data valid
//
// Modports: master (requester side), slave (arbiter side).
// ---------------------------------------------------------------------------
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface : onchip_mem_arbiter_if

// File: rtl/onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Purpose : shares the single slave port of a 32K x 32 on-chip RAM between
//           two Avalon-MM masters. At most one transfer is granted per
//           cycle (combinationally, in the request cycle). Conflicts are
//           resolved round-robin against the last granted port. The RAM's
//           fixed 1-cycle read latency is tracked so readdatavalid returns
//           to the master that issued the read. Per-port saturating stall
//           counters are kept for performance debug.
//
// Build option:
//   ONCHIP_MEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins a conflict
//                                  undefined -> round-robin
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   m0, m1         slave modport of onchip_mem_arbiter_if, one per master
//   mem_address    out  RAM word address
//   mem_byteenable out  RAM byte enables
//   mem_chipselect out  RAM chipselect (a transfer is granted)
//   mem_write      out  RAM write strobe
//   mem_writedata  out  RAM write data
//   mem_clken      out  RAM clock enable, constant 1
//   mem_readdata   in   RAM read data, valid 1 cycle after acceptance
//   stall_cnt0/1   out  cycles each master spent with waitrequest high
// ---------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [BE_W-1:0]     mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [CNT_W-1:0]    stall_cnt0,
  output logic [CNT_W-1:0]    stall_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic w_req0;
  logic w_req1;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;
  logic w_mem_write;

  logic             r_last_grant;  // port granted most recently (0 or 1)
  logic             r_rd_pend;     // a read was accepted last cycle
  logic             r_rd_owner;    // port that issued that read
  logic [CNT_W-1:0] r_stall_cnt0;
  logic [CNT_W-1:0] r_stall_cnt1;

  assign w_req0 = m0.read | m0.write;
  assign w_req1 = m1.read | m1.write;

  // Grant decision. Reset suppresses every grant so nothing reaches the RAM
  // while the tracking state is being cleared.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (w_req0 && !w_req1) begin
        w_gnt0 = 1'b1;
      end else if (w_req1 && !w_req0) begin
        w_gnt1 = 1'b1;
      end else if (w_req0 && w_req1) begin
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
        w_gnt0 = 1'b1;
`else
        // Round-robin: the port that was not granted last time wins.
        w_gnt0 = r_last_grant;
        w_gnt1 = ~r_last_grant;
`endif
      end
    end
  end

  assign w_any_gnt = w_gnt0 | w_gnt1;

  // A port raising read and write together is treated as a write; the read
  // half is dropped because rd_pend only follows non-write grants.
  assign w_mem_write = (w_gnt0 & m0.write) | (w_gnt1 & m1.write);

  // RAM side. Without a grant the port 0 fields are passed through; they are
  // don't-care because chipselect is low.
  assign mem_address    = w_gnt1 ? m1.address    : m0.address;
  assign mem_byteenable = w_gnt1 ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = w_gnt1 ? m1.writedata  : m0.writedata;
  assign mem_chipselect = w_any_gnt;
  assign mem_write      = w_mem_write;
  assign mem_clken      = 1'b1;

  // Master side. Read data is broadcast; only readdatavalid is steered.
  assign m0.waitrequest   = w_req0 & ~w_gnt0;
  assign m1.waitrequest   = w_req1 & ~w_gnt1;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = r_rd_pend & ~r_rd_owner;
  assign m1.readdatavalid = r_rd_pend &  r_rd_owner;

  assign stall_cnt0 = r_stall_cnt0;
  assign stall_cnt1 = r_stall_cnt1;

  // Grant history, read-return tracking and stall counters.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_stall_cnt0 <= '0;
      r_stall_cnt1 <= '0;
    end else begin
      if (w_any_gnt) begin
        r_last_grant <= w_gnt1;
      end
      // Every cycle is re-evaluated so back-to-back reads pipeline at one
      // per cycle and a write right after a read cannot disturb its return.
      r_rd_pend  <= w_any_gnt & ~w_mem_write;
      r_rd_owner <= w_gnt1;
      if (m0.waitrequest && (r_stall_cnt0 != CNT_MAX)) begin
        r_stall_cnt0 <= r_stall_cnt0 + 1'b1;
      end
      if (m1.waitrequest && (r_stall_cnt1 != CNT_MAX)) begin
        r_stall_cnt1 <= r_stall_cnt1 + 1'b1;
      end
    end
  end

endmodule : onchip_mem_arbiter

// File: tb/tb_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onchip_mem_arbiter
//
// Purpose : self-checking bench for onchip_mem_arbiter. A behavioural RAM
//           serves the DUT's memory port. A reference model decides, per
//           cycle, which pending master request is accepted, predicts
//           waitrequest, chipselect, write strobe and stall counts, keeps a
//           shadow copy of memory and queues the expected read returns.
//           A separate monitor pops those returns when the DUT presents
//           readdatavalid. Stall counters use a 4-bit width so saturation
//           is reached quickly. Honours ONCHIP_MEM_ARB_FIXED_PRIO_EN.
// ---------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic [CNT_W-1:0]  stall_cnt0;
  logic [CNT_W-1:0]  stall_cnt1;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_if ();

  onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m0            (m0_if.slave),
    .m1            (m1_if.slave),
    .mem_address   (mem_address),
    .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_writedata (mem_writedata),
    .mem_clken     (mem_clken),
    .mem_readdata  (mem_readdata),
    .stall_cnt0    (stall_cnt0),
    .stall_cnt1    (stall_cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with registered read data.
  logic [DATA_W-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  req_t cur [2];
  int   m_last;
  int   m_cnt [2];
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic req_t mk_rd(input logic [ADDR_W-1:0] a);
    req_t r;
    r = '0;
    r.rd = 1'b1;
    r.addr = a;
    return r;
  endfunction

  function automatic req_t mk_wr(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be,
                                 input logic [DATA_W-1:0] d);
    req_t r;
    r = '0;
    r.wr = 1'b1;
    r.addr = a;
    r.be = be;
    r.data = d;
    return r;
  endfunction

  function automatic bit busy(input int p);
    return cur[p].rd | cur[p].wr;
  endfunction

  // One clock cycle: drive pending requests, predict and compare the
  // combinational response, advance the model, wait for the next negedge.
  task automatic step(input logic rst);
    int   g;
    logic q [2];
    logic w [2];
    logic exp_we;
    exp_t e;
    reset = rst;
    m0_if.read = cur[0].rd;  m0_if.write = cur[0].wr;  m0_if.address = cur[0].addr;
    m0_if.byteenable = cur[0].be;  m0_if.writedata = cur[0].data;
    m1_if.read = cur[1].rd;  m1_if.write = cur[1].wr;  m1_if.address = cur[1].addr;
    m1_if.byteenable = cur[1].be;  m1_if.writedata = cur[1].data;
    #1;
    q[0] = busy(0);
    q[1] = busy(1);
    g = -1;
    if (!rst) begin
      if (q[0] && q[1]) begin
`ifdef ONCHIP_MEM_ARB_FIXED_PRIO_EN
        g = 0;
`else
        g = (m_last == 0) ? 1 : 0;
`endif
      end else if (q[0]) g = 0;
      else if (q[1]) g = 1;
    end
    w[0] = q[0] && (g != 0);
    w[1] = q[1] && (g != 1);
    exp_we = 1'b0;
    if (g >= 0) exp_we = cur[g].wr;
    check("m0_waitrequest", m0_if.waitrequest, w[0]);
    check("m1_waitrequest", m1_if.waitrequest, w[1]);
    check("stall_cnt0", stall_cnt0, m_cnt[0]);
    check("stall_cnt1", stall_cnt1, m_cnt[1]);
    check("mem_chipselect", mem_chipselect, g >= 0);
    check("mem_write", mem_write, exp_we);
    check("mem_clken", mem_clken, 1'b1);
    if (g >= 0) begin
      check("mem_address", mem_address, cur[g].addr);
      if (exp_we) begin
        check("mem_writedata", mem_writedata, cur[g].data);
        check("mem_byteenable", mem_byteenable, cur[g].be);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) m_cnt[i] = 0;
      else if (w[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
    end
    if (g >= 0) begin
      if (cur[g].wr) begin
        ref_mem[cur[g].addr] = merge(ref_mem[cur[g].addr], cur[g].data, cur[g].be);
      end else begin
        e.data = ref_mem[cur[g].addr];
        e.due  = cyc + 1;
        if (g == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
      end
      cur[g] = '0;
      m_last = g;
    end
    if (rst) m_last = 1;
    @(negedge clk);
  endtask

  // Monitor: every cycle, readdatavalid must match whether a return is due
  // now; when it is, the data must match the queued expectation.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      ev = (exp_q0.size() > 0) && (exp_q0[0].due == cyc);
      check("m0_readdatavalid", m0_if.readdatavalid, ev);
      if (ev && m0_if.readdatavalid) check("m0_readdata", m0_if.readdata, exp_q0[0].data);
      while (exp_q0.size() > 0 && exp_q0[0].due <= cyc) void'(exp_q0.pop_front());
      ev = (exp_q1.size() > 0) && (exp_q1[0].due == cyc);
      check("m1_readdatavalid", m1_if.readdatavalid, ev);
      if (ev && m1_if.readdatavalid) check("m1_readdata", m1_if.readdata, exp_q1[0].data);
      while (exp_q1.size() > 0 && exp_q1[0].due <= cyc) void'(exp_q1.pop_front());
    end
  end

  initial begin
    logic [2:0] sel;
    int         kind;
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]     = {a[15:0], ~a[15:0]};
      ref_mem[a] = {a[15:0], ~a[15:0]};
    end
    ram[15'h0010] = 32'hDEADBEEF;  ref_mem[15'h0010] = 32'hDEADBEEF;
    ram[15'h7FFF] = 32'hAABBCCDD;  ref_mem[15'h7FFF] = 32'hAABBCCDD;
    cur[0] = '0;
    cur[1] = '0;
    m_last = 1;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    reset = 1'b1;
    @(negedge clk);
    step(1'b1);
    step(1'b1);

    // Single read from m0.
    cur[0] = mk_rd(15'h0010);
    step(1'b0);
    step(1'b0);

    // Byte-enable write from m1, then read back.
    cur[1] = mk_wr(15'h7FFF, 4'b0101, 32'h11223344);
    step(1'b0);
    cur[1] = mk_rd(15'h7FFF);
    step(1'b0);
    step(1'b0);

    // Both masters read continuously for 6 cycles.
    for (int i = 0; i < 6; i++) begin
      if (!busy(0)) cur[0] = mk_rd(15'(16'h0020 + i));
      if (!busy(1)) cur[1] = mk_rd(15'(16'h0040 + i));
      step(1'b0);
    end
    cur[0] = '0;
    cur[1] = '0;
    step(1'b1);

    // Read in cycle N, write to the same word in N+1, read again later.
    cur[0] = mk_rd(15'h0100);
    step(1'b0);
    cur[1] = mk_wr(15'h0100, 4'b1111, 32'hCAFEF00D);
    step(1'b0);
    cur[0] = mk_rd(15'h0100);
    step(1'b0);
    step(1'b0);

    // Read presented during reset: never accepted, no return; then a
    // conflict confirms port 0 wins first after reset.
    cur[0] = mk_rd(15'h0010);
    step(1'b1);
    cur[0] = '0;
    step(1'b0);
    cur[0] = mk_rd(15'h0011);
    cur[1] = mk_rd(15'h0012);
    step(1'b0);
    step(1'b0);
    step(1'b0);

    // Long conflict: stall counters must saturate rather than wrap.
    step(1'b1);
    for (int i = 0; i < 40; i++) begin
      if (!busy(0)) cur[0] = mk_rd(15'(i));
      if (!busy(1)) cur[1] = mk_rd(15'(16'h7F00 + i));
      step(1'b0);
    end
    cur[0] = '0;
    cur[1] = '0;
    step(1'b1);

    // Randomized traffic over a small address set, with occasional resets.
    for (int n = 0; n < 500; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!busy(p) && $urandom_range(0, 99) < 60) begin
          sel  = 3'($urandom_range(0, 7));
          kind = $urandom_range(0, 9);
          cur[p] = mk_wr((sel[2] ? 15'h7FF0 : 15'h0010) + 15'(sel[1:0]),
                         4'($urandom_range(0, 15)), $urandom);
          cur[p].wr = (kind >= 6);
          cur[p].rd = (kind <= 5) || (kind == 9);
        end
      end
      step($urandom_range(0, 49) == 0);
    end

    cur[0] = '0;
    cur[1] = '0;
    for (int i = 0; i < 3; i++) step(1'b0);
    check("m0 returns outstanding", exp_q0.size(), 0);
    check("m1 returns outstanding", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_onchip_mem_arbiter
